// File: rtl/collision_scheduler.sv
// Per-frame collision scan: one shared rectangle-overlap comparator walks every
// object slot, fetching each through a 1-cycle-latency table port.
module collision_scheduler #(
  parameter int NUM_OBJ = 8,
  parameter int IDX_W   = 3
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_fStart,
  input  logic [18:0]        i_Player_Pos,
  input  logic [5:0]         i_Player_W,
  input  logic [5:0]         i_Player_H,
  output logic               o_Obj_Rd,
  output logic [IDX_W-1:0]   o_Obj_Idx,
  input  logic [18:0]        i_Obj_Pos,
  input  logic [5:0]         i_Obj_W,
  input  logic [5:0]         i_Obj_H,
  output logic               o_fBusy,
  output logic               o_fDone,
  output logic [NUM_OBJ-1:0] o_Hit_Mask,
  output logic               o_fAnyHit,
  output logic [1:0]         o_Dbg_State
);

  typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx;
  logic [NUM_OBJ-1:0] work_mask, mask_nx;
  logic [18:0]        pl_pos;
  logic [5:0]         pl_w, pl_h;
  logic               hit, last;

  // Read port: o_Obj_Rd is high for one cycle with o_Obj_Idx; the table answers
  // on i_Obj_* during the following cycle, which is always the CMP state.
  assign o_Obj_Rd    = (state == READ);
  assign o_Obj_Idx   = (state == READ) ? idx : '0;
  assign o_fBusy     = (state == READ) || (state == CMP);
  assign o_fDone     = (state == DONE);
  assign o_Dbg_State = state;

  // Sums are one bit wider than the coordinates so the far edges never wrap.
  logic [10:0] px, ox, px_end, ox_end;
  logic [9:0]  py, oy, py_end, oy_end;

  assign px     = {1'b0, pl_pos[18:9]};
  assign ox     = {1'b0, i_Obj_Pos[18:9]};
  assign py     = {1'b0, pl_pos[8:0]};
  assign oy     = {1'b0, i_Obj_Pos[8:0]};
  assign px_end = px + {5'b0, pl_w};
  assign ox_end = ox + {5'b0, i_Obj_W};
  assign py_end = py + {4'b0, pl_h};
  assign oy_end = oy + {4'b0, i_Obj_H};

  // Empty rectangles are excluded explicitly: a zero width still satisfies the
  // interval test when the other box straddles its position.
  assign hit = (px < ox_end) && (ox < px_end) && (py < oy_end) && (oy < py_end) &&
               (|pl_w) && (|pl_h) && (|i_Obj_W) && (|i_Obj_H);

  assign mask_nx = work_mask | (NUM_OBJ'(hit) << idx);
  assign last    = (idx == IDX_W'(NUM_OBJ - 1));

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_fStart) state_nx = READ;
      READ:    state_nx = CMP;
      CMP:     state_nx = last ? DONE : READ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      idx        <= '0;
      work_mask  <= '0;
      o_Hit_Mask <= '0;
      o_fAnyHit  <= 1'b0;
      pl_pos     <= '0;
      pl_w       <= '0;
      pl_h       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_fStart) begin
            pl_pos    <= i_Player_Pos;
            pl_w      <= i_Player_W;
            pl_h      <= i_Player_H;
            idx       <= '0;
            work_mask <= '0;
          end
        end
        CMP: begin
          work_mask <= mask_nx;
          if (last) begin
            o_Hit_Mask <= mask_nx;
            o_fAnyHit  <= |mask_nx;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Once per frame, checks the player sprite against every object slot using one shared rectangle-overlap comparator, time-multiplexed over the slots.
- Fetches each object's packed position and size from the object table through a 1-cycle-latency read port.
- Publishes a registered per-object hit mask and a done pulse to game logic.
- Started by the frame-start pulse (vertical blanking), so the scan never races the pixel pipeline.

Parameters:
- NUM_OBJ, 8, number of object slots scanned per frame (1..2^IDX_W).
- IDX_W, 3, width of the object index.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  reset, asynchronous, active-high
- i_fStart  in  1  frame-start pulse; starts a scan when the block is idle
- i_Player_Pos  in  19  player position, X=[18:9] (10b), Y=[8:0] (9b)
- i_Player_W  in  6  player width in pixels
- i_Player_H  in  6  player height in pixels
- o_Obj_Rd  out  1  object table read strobe
- o_Obj_Idx  out  IDX_W  object slot being read
- i_Obj_Pos  in  19  object position, same packing; valid the cycle after o_Obj_Rd
- i_Obj_W  in  6  object width; valid the cycle after o_Obj_Rd
- i_Obj_H  in  6  object height; valid the cycle after o_Obj_Rd
- o_fBusy  out  1  scan in progress
- o_fDone  out  1  one-cycle pulse: new results are valid
- o_Hit_Mask  out  NUM_OBJ  bit k=1: player overlaps object k (last completed scan)
- o_fAnyHit  out  1  OR of o_Hit_Mask

Behaviour:
- Reset (async, any time, including mid-scan):
  - State goes to IDLE.
  - idx, working mask, o_Hit_Mask, o_fAnyHit, o_fDone, o_fBusy, o_Obj_Rd all go to 0.
  - A partial scan is discarded.
- FSM states: IDLE, READ, CMP, DONE.
- IDLE:
  - On a clock edge with i_fStart=1: snapshot i_Player_Pos/W/H into registers, clear idx and the working mask, go to READ.
  - i_fStart=0: stay in IDLE.
- READ:
  - o_Obj_Rd=1 and o_Obj_Idx=idx, both decoded from state/idx registers.
  - Next edge: go to CMP.
- CMP:
  - Sample i_Obj_Pos/W/H and evaluate overlap against the snapshotted player.
  - Write the result to working-mask bit idx.
  - If idx==NUM_OBJ-1: load o_Hit_Mask with the final working mask, o_fAnyHit with its OR, and go to DONE.
  - Otherwise: idx+1, go to READ.
- DONE:
  - o_fDone=1 for exactly this one cycle.
  - Next edge: go to IDLE.
- o_fBusy=1 in READ and CMP only.
- o_Obj_Rd=0 and o_Obj_Idx=0 outside READ.
- Overlap rule (half-open rectangles):
  - hit = (Px < Ox+Ow) & (Ox < Px+Pw) & (Py < Oy+Oh) & (Oy < Py+Ph)
  - X sums are computed 11 bits wide, Y sums 10 bits wide, so sums never wrap.
  - Edges that only touch are not a hit.
  - W=0 or H=0 on either rectangle is never a hit.
- Latency:
  - Start edge at cycle N: first o_Obj_Rd at N+1; o_fDone at N+2*NUM_OBJ+1.
  - For NUM_OBJ=8, o_fDone is 17 cycles after the start edge.
- Result update:
  - o_Hit_Mask and o_fAnyHit change only on the edge entering DONE, all bits together.
  - They hold the previous frame's result throughout a scan.
- Start handling:
  - i_fStart in READ, CMP or DONE is ignored, not queued.
  - Only IDLE accepts a start.
- Player inputs changing during a scan have no effect; the snapshot is used.
- Object inputs are sampled only in CMP; values in other states are don't-care.

Test Plan:
- Reset then idle, no start: all outputs stay 0. Assert i_Rst mid-scan (idx=3): outputs clear immediately, and no o_fDone follows.
- Player (100,50,16,16), NUM_OBJ=4, objects:
  - 0: (110,60,8,8)
  - 1: (116,50,8,8), right edge touching
  - 2: (92,42,8,8), corner touching
  - 3: (93,43,8,8)
  - Required: o_Hit_Mask=4'b1001, o_fAnyHit=1, o_fDone 9 cycles after start.
- Zero size and no wrap:
  - Object (105,55,0,8) -> no hit.
  - Player (1000,500,20,10) vs object (1020,505,63,5) -> no hit (touching).
  - Object (1019,505,63,5) -> hit; the 11-bit sum does not wrap.
- Read handshake: o_Obj_Rd pulses once per slot with o_Obj_Idx=0,1,2,…,NUM_OBJ-1 on alternate cycles. The bench table responds one cycle later. Check that each index is read exactly once per scan.
- Start while busy:
  - Second i_fStart during a scan is ignored: exactly one o_fDone, and o_fBusy never re-asserts until the next IDLE start.
  - Changing i_Player_Pos mid-scan does not alter the mask.
  - The previous mask holds until DONE.
- Back-to-back frames: i_fStart asserted on the cycle right after DONE (IDLE) starts a new scan immediately. o_Hit_Mask switches atomically from the frame-1 to the frame-2 value at the second DONE.
